// File: rtl/light_phase_timer_pkg.sv
// Shared types and constants for the light phase timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package light_phase_timer_pkg;

  localparam int TIME_W        = 7;
  localparam int DEFAULT_GREEN = 20;

  // Encoding is visible on the phase output, so the values are fixed.
  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    REQ     = 2'd1,
    GREEN   = 2'd2,
    YELLOW  = 2'd3
  } phase_t;

  // Each direction drives a pair of adjacent lamp bits.
  localparam logic [7:0] LANE_N = 8'h03;
  localparam logic [7:0] LANE_E = 8'h0C;
  localparam logic [7:0] LANE_S = 8'h30;
  localparam logic [7:0] LANE_W = 8'hC0;

  // A grant is only acceptable when it names exactly one whole direction pair.
  function automatic logic isPairCode(input logic [7:0] req);
    return (req == LANE_N) || (req == LANE_E) || (req == LANE_S) || (req == LANE_W);
  endfunction

endpackage

// File: rtl/light_phase_timer_phase_countdown.sv
// Per-phase tick countdown: a phase loaded with N expires on its Nth tick.
// Latency: load/decrement visible one clk later; expire is combinational.
// Backpressure: none; tick is a free-running enable, load overrides it.
module phase_countdown #(
  parameter int TIME_W      = 7,
  parameter int RESET_VALUE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] loadValue,
  input  logic              tick,
  output logic [TIME_W-1:0] count,
  output logic              expire
);

  localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

  // The last tick of a phase is the one that lands while count is 1.
  assign expire = tick & (count == ONE);

  // Count never goes below 1; the owner reloads on expiry instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= TIME_W'(RESET_VALUE);
    end else if (load) begin
      count <= loadValue;
    end else if (tick && (count > ONE)) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/light_phase_timer.sv
// Lamp sequencer: takes a lane-pair grant, runs GREEN -> YELLOW -> ALL_RED, asks for the next grant.
// Latency: phase, count and lamps all change on the same clk edge; isZero is high for the one REQ clk.
// Backpressure: none; the grant is sampled unconditionally on the clk after isZero.
module light_phase_timer #(
  parameter int TIME_W        = light_phase_timer_pkg::TIME_W,
  parameter int DEFAULT_GREEN = light_phase_timer_pkg::DEFAULT_GREEN,
  parameter int YELLOW_TIME   = 3,
  parameter int ALLRED_TIME   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [7:0]        laneRequest,
  input  logic [TIME_W-1:0] loadTimer,
  output logic              isZero,
  output logic [7:0]        green,
  output logic [7:0]        yellow,
  output logic [7:0]        red,
  output logic [1:0]        phase,
  output logic [TIME_W-1:0] count,
  output logic              badGrant
);

  import light_phase_timer_pkg::*;

  phase_t            state;
  phase_t            stateNext;
  logic [7:0]        grant;
  logic [7:0]        grantNext;
  logic              badNext;
  logic              load;
  logic [TIME_W-1:0] loadValue;
  logic              expire;
  logic [TIME_W-1:0] greenTime;
  logic [7:0]        greenNext;
  logic [7:0]        yellowNext;
  logic [7:0]        redNext;

  phase_countdown #(
    .TIME_W      (TIME_W),
    .RESET_VALUE (ALLRED_TIME)
  ) u_countdown (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .loadValue (loadValue),
    .tick      (tick),
    .count     (count),
    .expire    (expire)
  );

  // A zero duration from the selector means "use the default green".
  assign greenTime = (loadTimer == '0) ? TIME_W'(DEFAULT_GREEN) : loadTimer;

  // Phase sequencing: REQ always resolves in one clk, ticks there are ignored.
  always_comb begin
    stateNext = state;
    grantNext = grant;
    badNext   = badGrant;
    load      = 1'b0;
    loadValue = '0;
    case (state)
      ALL_RED: begin
        if (expire) begin
          stateNext = REQ;
        end
      end
      REQ: begin
        load = 1'b1;
        if (isPairCode(laneRequest)) begin
          stateNext = GREEN;
          grantNext = laneRequest;
          loadValue = greenTime;
        end else begin
          // Refuse the grant, clear again and re-request.
          stateNext = ALL_RED;
          grantNext = 8'h00;
          badNext   = 1'b1;
          loadValue = TIME_W'(ALLRED_TIME);
        end
      end
      GREEN: begin
        if (expire) begin
          stateNext = YELLOW;
          load      = 1'b1;
          loadValue = TIME_W'(YELLOW_TIME);
        end
      end
      YELLOW: begin
        if (expire) begin
          stateNext = ALL_RED;
          grantNext = 8'h00;
          load      = 1'b1;
          loadValue = TIME_W'(ALLRED_TIME);
        end
      end
      default: begin
        stateNext = ALL_RED;
        grantNext = 8'h00;
        load      = 1'b1;
        loadValue = TIME_W'(ALLRED_TIME);
      end
    endcase
  end

  // Lamps decode from the next state so they move on the same edge as phase.
  always_comb begin
    greenNext  = 8'h00;
    yellowNext = 8'h00;
    redNext    = 8'hFF;
    case (stateNext)
      GREEN: begin
        greenNext = grantNext;
        redNext   = ~grantNext;
      end
      YELLOW: begin
        yellowNext = grantNext;
        redNext    = ~grantNext;
      end
      default: begin
        redNext = 8'hFF;
      end
    endcase
  end

  // State, grant, sticky error and lamp registers; reset drops straight to all-red.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ALL_RED;
      grant    <= 8'h00;
      badGrant <= 1'b0;
      isZero   <= 1'b0;
      green    <= 8'h00;
      yellow   <= 8'h00;
      red      <= 8'hFF;
    end else begin
      state    <= stateNext;
      grant    <= grantNext;
      badGrant <= badNext;
      isZero   <= (stateNext == REQ);
      green    <= greenNext;
      yellow   <= yellowNext;
      red      <= redNext;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_light_phase_timer.sv
// Scoreboard bench for light_phase_timer: planned stimulus steps carry their expected outputs.
// Latency: each step is one clk; outputs are sampled 1 ns after the rising edge.
// Backpressure: n/a.
module tb_light_phase_timer;

  localparam logic [1:0] P_AR  = 2'd0;
  localparam logic [1:0] P_REQ = 2'd1;
  localparam logic [1:0] P_G   = 2'd2;
  localparam logic [1:0] P_Y   = 2'd3;

  typedef struct packed {
    logic [1:0] ph;
    logic [6:0] cnt;
    logic [7:0] g;
    logic [7:0] y;
    logic [7:0] r;
    logic       z;
    logic       b;
  } obs_t;

  typedef struct {
    logic       r;
    logic       t;
    logic [7:0] lane;
    logic [6:0] load;
    obs_t       exp;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] laneRequest = 8'h00;
  logic [6:0] loadTimer = 7'd0;
  logic       isZero;
  logic [7:0] green;
  logic [7:0] yellow;
  logic [7:0] red;
  logic [1:0] phase;
  logic [6:0] count;
  logic       badGrant;

  int errors = 0;
  int checks = 0;

  stim_t sq[$];
  obs_t  eq[$];

  light_phase_timer dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .laneRequest (laneRequest),
    .loadTimer   (loadTimer),
    .isZero      (isZero),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .phase       (phase),
    .count       (count),
    .badGrant    (badGrant)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] ph, input int cnt, input logic [7:0] gr,
                              input logic z, input logic b);
    obs_t o;
    o.ph  = ph;
    o.cnt = 7'(cnt);
    o.g   = 8'h00;
    o.y   = 8'h00;
    o.r   = 8'hFF;
    o.z   = z;
    o.b   = b;
    if (ph == P_G) begin
      o.g = gr;
      o.r = ~gr;
    end else if (ph == P_Y) begin
      o.y = gr;
      o.r = ~gr;
    end
    return o;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o.ph  = phase;
    o.cnt = count;
    o.g   = green;
    o.y   = yellow;
    o.r   = red;
    o.z   = isZero;
    o.b   = badGrant;
    return o;
  endfunction

  task automatic plan(input logic r, input logic t, input logic [7:0] lane,
                      input logic [6:0] load, input obs_t e);
    stim_t s;
    s.r = r; s.t = t; s.lane = lane; s.load = load; s.exp = e;
    sq.push_back(s);
  endtask

  // Yellow for 3 ticks, one all-red tick, then the next request; junk on the grant inputs.
  task automatic planTail(input logic [7:0] gr, input logic b);
    plan(0, 1, 8'hAA, 7'h55, mk(P_Y, 3, gr, 0, b));
    plan(0, 1, 8'hAA, 7'h55, mk(P_Y, 2, gr, 0, b));
    plan(0, 1, 8'hAA, 7'h55, mk(P_Y, 1, gr, 0, b));
    plan(0, 1, 8'hAA, 7'h55, mk(P_AR, 1, 8'h00, 0, b));
    plan(0, 1, 8'hAA, 7'h55, mk(P_REQ, 1, 8'h00, 1, b));
  endtask

  task automatic drive(input stim_t s);
    rst = s.r; tick = s.t; laneRequest = s.lane; loadTimer = s.load;
    eq.push_back(s.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    int n = 0;
    plan(1, 0, 8'h03, 7'd5, mk(P_AR, 1, 8'h00, 0, 0));
    plan(1, 1, 8'h03, 7'd5, mk(P_AR, 1, 8'h00, 0, 0));
    plan(0, 0, 8'h03, 7'd5, mk(P_AR, 1, 8'h00, 0, 0));
    plan(0, 1, 8'h03, 7'd5, mk(P_REQ, 1, 8'h00, 1, 0));
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front(); o = snap(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset step %0d: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_grant_n();
    obs_t e, o;
    int n = 0;
    plan(0, 0, 8'h03, 7'd5, mk(P_G, 5, 8'h03, 0, 0));
    for (int i = 4; i >= 1; i--) begin
      plan(0, 1, 8'h03, 7'd5, mk(P_G, i, 8'h03, 0, 0));
      plan(0, 0, 8'h03, 7'd5, mk(P_G, i, 8'h03, 0, 0));
    end
    planTail(8'h03, 0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front(); o = snap(); checks++;
      if (o !== e) begin errors++; $display("FAIL grant_n step %0d: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_default_green();
    obs_t e, o;
    int n = 0;
    plan(0, 0, 8'hC0, 7'd0, mk(P_G, 20, 8'hC0, 0, 0));
    for (int i = 19; i >= 1; i--) plan(0, 1, 8'hC0, 7'd0, mk(P_G, i, 8'hC0, 0, 0));
    planTail(8'hC0, 0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front(); o = snap(); checks++;
      if (o !== e) begin errors++; $display("FAIL default_green step %0d: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_max_green();
    obs_t e, o;
    int n = 0;
    plan(0, 0, 8'h30, 7'd127, mk(P_G, 127, 8'h30, 0, 0));
    for (int i = 126; i >= 1; i--) plan(0, 1, 8'h30, 7'd127, mk(P_G, i, 8'h30, 0, 0));
    planTail(8'h30, 0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front(); o = snap(); checks++;
      if (o !== e) begin errors++; $display("FAIL max_green step %0d: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_req_tick_midgreen();
    obs_t e, o;
    int n = 0;
    // Tick during REQ must not shorten the freshly loaded green.
    plan(0, 1, 8'h0C, 7'd4, mk(P_G, 4, 8'h0C, 0, 0));
    plan(0, 1, 8'h30, 7'd9, mk(P_G, 3, 8'h0C, 0, 0));
    plan(0, 0, 8'hC0, 7'd0, mk(P_G, 3, 8'h0C, 0, 0));
    plan(0, 1, 8'h0F, 7'd1, mk(P_G, 2, 8'h0C, 0, 0));
    plan(0, 1, 8'h00, 7'd2, mk(P_G, 1, 8'h0C, 0, 0));
    planTail(8'h0C, 0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front(); o = snap(); checks++;
      if (o !== e) begin errors++; $display("FAIL req_tick_midgreen step %0d: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_illegal();
    obs_t e, o;
    int n = 0;
    plan(0, 0, 8'h0F, 7'd5, mk(P_AR, 1, 8'h00, 0, 1));
    plan(0, 0, 8'h0F, 7'd5, mk(P_AR, 1, 8'h00, 0, 1));
    plan(0, 1, 8'h0F, 7'd5, mk(P_REQ, 1, 8'h00, 1, 1));
    plan(0, 0, 8'h00, 7'd5, mk(P_AR, 1, 8'h00, 0, 1));
    plan(0, 1, 8'h00, 7'd5, mk(P_REQ, 1, 8'h00, 1, 1));
    plan(0, 0, 8'h01, 7'd5, mk(P_AR, 1, 8'h00, 0, 1));
    plan(0, 1, 8'h01, 7'd5, mk(P_REQ, 1, 8'h00, 1, 1));
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front(); o = snap(); checks++;
      if (o !== e) begin errors++; $display("FAIL illegal step %0d: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_rst_mid_green();
    obs_t e, o;
    int n = 0;
    plan(0, 0, 8'h03, 7'd6, mk(P_G, 6, 8'h03, 0, 1));
    plan(0, 1, 8'h03, 7'd6, mk(P_G, 5, 8'h03, 0, 1));
    plan(0, 1, 8'h03, 7'd6, mk(P_G, 4, 8'h03, 0, 1));
    plan(0, 1, 8'h03, 7'd6, mk(P_G, 3, 8'h03, 0, 1));
    plan(1, 1, 8'h03, 7'd6, mk(P_AR, 1, 8'h00, 0, 0));
    plan(0, 0, 8'h03, 7'd6, mk(P_AR, 1, 8'h00, 0, 0));
    plan(0, 1, 8'h03, 7'd6, mk(P_REQ, 1, 8'h00, 1, 0));
    plan(0, 0, 8'h0C, 7'd2, mk(P_G, 2, 8'h0C, 0, 0));
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front(); o = snap(); checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid_green step %0d: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_grant_n();
    test_default_green();
    test_max_green();
    test_req_tick_midgreen();
    test_illegal();
    test_rst_mid_green();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
